// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one ALU op, waits LAT cycles, streams result words to the bus
module alu_op_sequencer #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12,
    parameter int LAT       = 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [3:0]             opcode,
    input  logic [BITS-1:0]        x_in,
    input  logic [BITS-1:0]        y_in,
    output logic [SIG_COUNT-1:0]   ctrl_signal,
    output logic [BITS-1:0]        alu_x,
    output logic [BITS-1:0]        alu_y,
    input  logic [2*BITS-1:0]      alu_result,
    output logic [BITS-1:0]        bus_out,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic [BITS-1:0]        zhi,
    output logic [BITS-1:0]        zlo,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SEND_LO,
        S_SEND_HI,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] op_q;
    logic [3:0] cnt;
    logic       accept;
    logic       illegal;
    logic       settle_last;
    logic       xfer;

    assign accept      = (state == S_IDLE) && start && (opcode <= 4'd11);
    assign illegal     = (state == S_IDLE) && start && (opcode > 4'd11);
    assign settle_last = (cnt == 4'(LAT - 1));
    assign xfer        = bus_valid && bus_ready;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (accept) state_nx = S_ISSUE;
            S_ISSUE:   if (settle_last) state_nx = S_SEND_LO;
            // only mul and div produce a meaningful upper word
            S_SEND_LO: if (xfer) state_nx = ((op_q == 4'd2) || (op_q == 4'd3)) ? S_SEND_HI : S_DONE;
            S_SEND_HI: if (xfer) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q  <= '0;
            cnt   <= '0;
            alu_x <= '0;
            alu_y <= '0;
            zhi   <= '0;
            zlo   <= '0;
            err   <= 1'b0;
        end else begin
            err <= illegal;
            if (accept) begin
                op_q  <= opcode;
                alu_x <= x_in;
                alu_y <= y_in;
                cnt   <= '0;
            end else if (state == S_ISSUE) begin
                if (settle_last) begin
                    zhi <= alu_result[2*BITS-1:BITS];
                    zlo <= alu_result[BITS-1:0];
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    always_comb begin
        ctrl_signal = '0;
        bus_valid   = 1'b0;
        bus_out     = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_ISSUE: begin
                ctrl_signal = {{(SIG_COUNT-1){1'b0}}, 1'b1} << op_q;
                busy        = 1'b1;
            end
            S_SEND_LO: begin
                bus_valid = 1'b1;
                bus_out   = zlo;
                busy      = 1'b1;
            end
            S_SEND_HI: begin
                bus_valid = 1'b1;
                bus_out   = zhi;
                busy      = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed vector bench for alu_op_sequencer (LAT=1 and LAT=3 instances)
module tb_alu_op_sequencer;

    logic        clk;
    logic        clr;
    logic        start;
    logic [3:0]  opcode;
    logic [31:0] x_in, y_in;
    logic        bus_ready;

    logic [11:0] ctrl_a, ctrl_b;
    logic [31:0] alu_x_a, alu_y_a, alu_x_b, alu_y_b;
    logic [63:0] alu_result_a, alu_result_b;
    logic [31:0] bus_out_a, bus_out_b, zhi_a, zlo_a, zhi_b, zlo_b;
    logic        bus_valid_a, bus_valid_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        two;
        string       name;
    } vec_t;

    vec_t vecs[12];

    alu_op_sequencer #(.BITS(32), .SIG_COUNT(12), .LAT(1)) dut_a (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .x_in(x_in), .y_in(y_in),
        .ctrl_signal(ctrl_a), .alu_x(alu_x_a), .alu_y(alu_y_a), .alu_result(alu_result_a),
        .bus_out(bus_out_a), .bus_valid(bus_valid_a), .bus_ready(bus_ready),
        .zhi(zhi_a), .zlo(zlo_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    alu_op_sequencer #(.BITS(32), .SIG_COUNT(12), .LAT(3)) dut_b (
        .clk(clk), .clr(clr), .start(start), .opcode(opcode), .x_in(x_in), .y_in(y_in),
        .ctrl_signal(ctrl_b), .alu_x(alu_x_b), .alu_y(alu_y_b), .alu_result(alu_result_b),
        .bus_out(bus_out_b), .bus_valid(bus_valid_b), .bus_ready(bus_ready),
        .zhi(zhi_b), .zlo(zlo_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    function automatic logic [63:0] alu_f(input logic [11:0] c, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic [5:0]  s;
        s = {1'b0, y[4:0]};
        r = '0;
        if (c[2]) return {32'b0, x} * {32'b0, y};
        if (c[3]) return (y == 0) ? 64'd0 : {x % y, x / y};
        case (1'b1)
            c[0]:  r = x + y;
            c[1]:  r = x - y;
            c[4]:  r = x >> s;
            c[5]:  r = x << s;
            c[6]:  r = (x >> s) | (x << (6'd32 - s));
            c[7]:  r = (x << s) | (x >> (6'd32 - s));
            c[8]:  r = x & y;
            c[9]:  r = x | y;
            c[10]: r = -x;
            c[11]: r = ~x;
            default: r = '0;
        endcase
        return {32'b0, r};
    endfunction

    always_comb alu_result_a = alu_f(ctrl_a, alu_x_a, alu_y_a);
    always_comb alu_result_b = alu_f(ctrl_b, alu_x_b, alu_y_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b || done_a || done_b) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", (n >= 60) ? 1 : 0, 0);
    endtask

    task automatic run_a(input vec_t v);
        logic [11:0] ec;
        int n;
        ec = 12'd1 << v.op;
        @(negedge clk);
        start = 1'b1; opcode = v.op; x_in = v.x; y_in = v.y;
        @(negedge clk);
        start = 1'b0;
        chk({v.name, "_ctrl"}, ctrl_a, ec);
        n = 0;
        while (!bus_valid_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({v.name, "_valid"}, bus_valid_a, 1);
        chk({v.name, "_lo"}, bus_out_a, v.lo);
        @(negedge clk);
        if (v.two) begin
            chk({v.name, "_hi"}, bus_out_a, v.hi);
            @(negedge clk);
        end
        chk({v.name, "_done"}, done_a, 1);
        chk({v.name, "_zlo"}, zlo_a, v.lo);
        chk({v.name, "_zhi"}, zhi_a, v.hi);
        wait_idle();
    endtask

    initial begin
        int busy_n, ctrl_n, valid_n, done_n, first_valid, bad_out;
        vec_t v;

        vecs[0]  = '{4'd0,  32'd5,          32'd7,       32'd12,         32'd0, 1'b0, "add"};
        vecs[1]  = '{4'd1,  32'd9,          32'd4,       32'd5,          32'd0, 1'b0, "sub"};
        vecs[2]  = '{4'd2,  32'h10000,      32'h10000,   32'd0,          32'd1, 1'b1, "mul"};
        vecs[3]  = '{4'd3,  32'd100,        32'd7,       32'd14,         32'd2, 1'b1, "div"};
        vecs[4]  = '{4'd4,  32'h80,         32'd3,       32'h10,         32'd0, 1'b0, "shr"};
        vecs[5]  = '{4'd5,  32'd1,          32'd4,       32'h10,         32'd0, 1'b0, "shl"};
        vecs[6]  = '{4'd6,  32'd1,          32'd1,       32'h80000000,   32'd0, 1'b0, "ror"};
        vecs[7]  = '{4'd7,  32'h80000000,   32'd1,       32'd1,          32'd0, 1'b0, "rol"};
        vecs[8]  = '{4'd8,  32'hF0,         32'h3C,      32'h30,         32'd0, 1'b0, "and"};
        vecs[9]  = '{4'd9,  32'hF0,         32'h0F,      32'hFF,         32'd0, 1'b0, "or"};
        vecs[10] = '{4'd10, 32'd5,          32'd0,       32'hFFFFFFFB,   32'd0, 1'b0, "neg"};
        vecs[11] = '{4'd11, 32'd0,          32'd0,       32'hFFFFFFFF,   32'd0, 1'b0, "not"};

        clr = 1'b0; start = 1'b0; opcode = '0; x_in = '0; y_in = '0; bus_ready = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", ctrl_a, 0);
        chk("rst_busy_valid_done_err", {busy_a, bus_valid_a, done_a, err_a}, 0);
        chk("rst_bus_out", bus_out_a, 0);
        chk("rst_z", {zhi_a, zlo_a}, 0);
        chk("rst_alu_xy", {alu_x_a, alu_y_a}, 0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_a(vecs[i]);

        // add 5+7 on LAT=1: cycle counts of each output
        busy_n = 0; ctrl_n = 0; valid_n = 0; done_n = 0; bad_out = 0;
        @(negedge clk);
        start = 1'b1; opcode = 4'd0; x_in = 32'd5; y_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            busy_n += busy_a;
            if (ctrl_a == 12'h001) ctrl_n++;
            if (bus_valid_a) begin
                valid_n++;
                if (bus_out_a != 32'd12) bad_out++;
            end
            done_n += done_a;
            @(negedge clk);
        end
        chk("add_busy_cycles", busy_n, 2);
        chk("add_ctrl_cycles", ctrl_n, 1);
        chk("add_valid_cycles", valid_n, 1);
        chk("add_bus_value", bad_out, 0);
        chk("add_done_pulses", done_n, 1);
        wait_idle();

        // sub 9-4 on LAT=3 with bus_ready low for 4 valid cycles
        ctrl_n = 0; valid_n = 0; done_n = 0; bad_out = 0; first_valid = -1;
        @(negedge clk);
        start = 1'b1; opcode = 4'd1; x_in = 32'd9; y_in = 32'd4; bus_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (ctrl_b == 12'h002) ctrl_n++;
            if (bus_valid_b) begin
                valid_n++;
                if (first_valid < 0) first_valid = i;
                if (bus_out_b != 32'd5) bad_out++;
            end
            done_n += done_b;
        end
        chk("lat3_ctrl_cycles", ctrl_n, 3);
        chk("lat3_first_valid", first_valid, 4);
        chk("lat3_valid_held", valid_n, 4);
        chk("lat3_out_stable", bad_out, 0);
        chk("lat3_no_early_done", done_n, 0);
        bus_ready = 1'b1;
        @(negedge clk);
        chk("lat3_done_after_xfer", done_b, 1);
        chk("lat3_bus_out_idle_zero", {bus_valid_b, bus_out_b}, 0);
        wait_idle();

        // illegal opcode
        @(negedge clk);
        start = 1'b1; opcode = 4'd13; x_in = 32'd1; y_in = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_err", err_a, 1);
        chk("illegal_ctrl_busy", {ctrl_a, busy_a}, 0);
        @(negedge clk);
        chk("illegal_err_one_cycle", {err_a, busy_a, ctrl_a}, 0);

        // async clear during SEND_HI of a div
        @(negedge clk);
        start = 1'b1; opcode = 4'd3; x_in = 32'd100; y_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("div_in_send_hi", {bus_valid_a, bus_out_a}, {1'b1, 32'd2});
        #2 clr = 1'b0;
        #1;
        chk("clr_async_bus", {bus_valid_a, bus_out_a, busy_a, done_a, err_a}, 0);
        chk("clr_async_regs", {zhi_a, zlo_a}, 0);
        chk("clr_async_misc", {ctrl_a, alu_x_a, busy_b}, 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        v = vecs[8];
        v.name = "and_after_clr";
        run_a(v);

        // start during busy and during DONE is ignored
        done_n = 0;
        @(negedge clk);
        start = 1'b1; opcode = 4'd0; x_in = 32'd1; y_in = 32'd2; bus_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            done_n += done_a;
            if (i < 3) begin
                start = 1'b1; opcode = 4'd2; x_in = 32'd9; y_in = 32'd9;
            end
            if (i == 2) begin
                chk("busy_ignore_bus_out", bus_out_a, 3);
                bus_ready = 1'b1;
            end
            if (i == 3) begin
                chk("done_seen", done_a, 1);
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
        end
        chk("one_done_per_start", done_n, 1);
        chk("ignored_start_idle", {busy_a, busy_b}, 0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter BITS, default 32, operand width.
REQ-002 Parameter SIG_COUNT, default 12, one-hot ALU control width.
REQ-003 Parameter LAT, default 1, ALU settle cycles per operation, legal range 1-15.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 clr  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  operation request, sampled only in IDLE.
REQ-007 opcode  in  4  ALU op index: 0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not.
REQ-008 x_in, y_in  in  BITS each  operands, sampled with start.
REQ-009 ctrl_signal  out  SIG_COUNT  one-hot ALU select.
REQ-010 alu_x, alu_y  out  BITS each  registered operands to the ALU.
REQ-011 alu_result  in  2*BITS  ALU operation result.
REQ-012 bus_out  out  BITS  result word to the bus.
REQ-013 bus_valid  out  1  bus_out holds a valid word.
REQ-014 bus_ready  in  1  bus accepts the word.
REQ-015 zhi, zlo  out  BITS each  captured result, upper and lower halves.
REQ-016 busy  out  1  operation in progress.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 err  out  1  one-cycle illegal-opcode pulse.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, SEND_LO, SEND_HI and DONE.
REQ-020 In IDLE with start=1 and opcode<=11, the edge SHALL register x_in/y_in into alu_x/alu_y, clear the settle counter and enter ISSUE.
REQ-021 In IDLE with start=1 and opcode>=12, the edge SHALL pulse err for exactly the next cycle and remain in IDLE with no other output change.
REQ-022 ctrl_signal SHALL equal 1<<opcode while in ISSUE and SHALL be all-zero in every other state.
REQ-023 ISSUE SHALL last exactly LAT cycles; the edge ending the LAT-th cycle SHALL load zhi<=alu_result[2*BITS-1:BITS] and zlo<=alu_result[BITS-1:0] and enter SEND_LO.
REQ-024 In SEND_LO, bus_valid=1 and bus_out=zlo; bus_out SHALL be 0 whenever bus_valid=0.
REQ-025 A word SHALL transfer on an edge where bus_valid=1 and bus_ready=1; bus_out SHALL hold stable until that edge.
REQ-026 After the SEND_LO transfer, opcode 2 or 3 SHALL go to SEND_HI (bus_out=zhi); any other opcode SHALL go to DONE.
REQ-027 After the SEND_HI transfer the FSM SHALL go to DONE.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 busy SHALL be 1 in ISSUE, SEND_LO and SEND_HI, and 0 in IDLE and DONE.
REQ-030 start SHALL be ignored in every state except IDLE, including DONE.
REQ-031 The opcode SHALL be latched at acceptance; input changes during an operation SHALL have no effect.
REQ-032 zhi/zlo SHALL hold their values until the next capture.
REQ-033 Minimum latency from start to the first bus_valid SHALL be LAT+1 cycles.

Reset
REQ-034 clr=0 SHALL immediately force IDLE and zero every output and internal register, regardless of clk, including mid-operation.
REQ-035 After clr is released, the first start SHALL behave as in REQ-020 with no residue from an aborted operation.

Verification
REQ-036 LAT=1, add 5+7, bus_ready=1 -> ctrl_signal=0x001 for 1 cycle; bus_out=12 with bus_valid for 1 cycle; done pulse; busy for 2 cycles.
REQ-037 mul 0x10000 x 0x10000, bus_ready=1 -> zlo=0, zhi=1; bus_out=0 then 1 on consecutive cycles, then done.
REQ-038 LAT=3, sub 9-4, bus_ready held 0 for 4 cycles -> ctrl_signal=0x002 for 3 cycles; bus_out=5 held stable with bus_valid until bus_ready=1; no done before the transfer.
REQ-039 opcode=13 with start -> err pulse for 1 cycle; ctrl_signal stays 0; busy stays 0.
REQ-040 clr=0 during SEND_HI of a div -> all outputs 0 asynchronously; after release, and 0xF0 & 0x3C -> bus_out=0x30.
REQ-041 start asserted during busy and during DONE -> ignored; exactly one done per accepted start.
